chip8_mem: RTL and testbench

Byte-wide 4 KiB CHIP-8 main memory, and the responder end of the CPU memory handshake (read request/ack plus fire-and-forget write). It serves the CPU port and a second, lower-priority read-only port for display scanout. Both share one single-port array.

---
 rtl/chip8_mem.sv | 129 ++++++++++++
 tb/tb_chip8_mem.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/chip8_mem.sv
// CHIP-8 4 KiB byte memory: CPU read/write port plus lower-priority display read port on one array.
// Optional FONT_ROM_EN overlays the hex font ROM on 0x050..0x09F (read-only).
module chip8_mem #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_ack,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [7:0]        disp_data,
    output logic              disp_ack,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic              own_cpu;
    logic [7:0]        cap;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_data;
    logic              wr_en;

    // CPU wins arbitration, so its address feeds the array whenever it asks
    assign sel_addr = rd_req ? rd_addr : disp_addr;

`ifdef FONT_ROM_EN
    localparam logic [0:79][7:0] FONT = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    function automatic logic in_font(input logic [ADDR_W-1:0] a);
        return (32'(a) >= 32'h50) && (32'(a) <= 32'h9F);
    endfunction

    logic [6:0] fidx;
    assign fidx     = 7'(32'(sel_addr) - 32'h50);
    assign sel_data = in_font(sel_addr) ? FONT[fidx] : mem[sel_addr];
    assign wr_en    = wr_req && !in_font(wr_addr);
`else
    assign sel_data = mem[sel_addr];
    assign wr_en    = wr_req;
`endif

    // Array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            own_cpu   <= 1'b0;
            cap       <= '0;
            rd_ack    <= 1'b0;
            disp_ack  <= 1'b0;
            rd_data   <= '0;
            disp_data <= '0;
            busy      <= 1'b0;
        end else begin
            rd_ack    <= 1'b0;
            disp_ack  <= 1'b0;
            rd_data   <= '0;
            disp_data <= '0;
            case (state)
                IDLE: begin
                    // Any write owns the single port this cycle; reads retry next cycle
                    if (!wr_req && (rd_req || disp_req)) begin
                        own_cpu <= rd_req;
                        cap     <= sel_data;
                        busy    <= 1'b1;
                        if (READ_LATENCY == 1) begin
                            state <= ACK;
                            if (rd_req) begin
                                rd_ack  <= 1'b1;
                                rd_data <= sel_data;
                            end else begin
                                disp_ack  <= 1'b1;
                                disp_data <= sel_data;
                            end
                        end else begin
                            state <= WAIT;
                            cnt   <= 3'(READ_LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        state <= ACK;
                        if (own_cpu) begin
                            rd_ack  <= 1'b1;
                            rd_data <= cap;
                        end else begin
                            disp_ack  <= 1'b1;
                            disp_data <= cap;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chip8_mem.sv
// Bench for chip8_mem: two instances (READ_LATENCY 1 and 4) against a flat byte-array model.
module tb_chip8_mem;
    localparam int NI = 2;

    logic                  clk;
    logic [NI-1:0]         rst_n, rd_req, wr_req, disp_req;
    logic [NI-1:0][11:0]   rd_addr, wr_addr, disp_addr;
    logic [NI-1:0][7:0]    wr_data, rd_data, disp_data;
    logic [NI-1:0]         rd_ack, disp_ack, busy;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] mdl   [NI][4096];
    bit         known [NI][4096];
    byte unsigned FONT [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    for (genvar g = 0; g < NI; g++) begin : gi
        chip8_mem #(.READ_LATENCY(g == 0 ? 1 : 4), .ADDR_W(12)) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .rd_req(rd_req[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]), .rd_ack(rd_ack[g]),
            .wr_req(wr_req[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
            .disp_req(disp_req[g]), .disp_addr(disp_addr[g]), .disp_data(disp_data[g]),
            .disp_ack(disp_ack[g]), .busy(busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic bit is_font(int a);
`ifdef FONT_ROM_EN
        return (a >= 'h50) && (a <= 'h9F);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] m_read(int k, int a);
        if (is_font(a)) return FONT[a - 'h50];
        return mdl[k][a];
    endfunction

    task automatic m_write(int k, int a, int d);
        if (!is_font(a)) begin
            mdl[k][a]   = 8'(d);
            known[k][a] = 1'b1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge
    task automatic wr(int k, int a, int d);
        wr_req[k] = 1'b1; wr_addr[k] = 12'(a); wr_data[k] = 8'(d);
        @(negedge clk);
        wr_req[k] = 1'b0;
        m_write(k, a, d);
    endtask

    task automatic wait_ack(int k, bit cpu, string tag, int n0, int exp_lat, logic [7:0] exp);
        int n = n0;
        bit got = 1'b0;
        int busy_low = 0;
        while (!got && n < n0 + 30) begin
            @(negedge clk);
            n++;
            if (busy[k] !== 1'b1) busy_low++;
            got = cpu ? rd_ack[k] : disp_ack[k];
        end
        chk({tag, "_acked"}, 32'(got), 1);
        chk({tag, "_busy"}, busy_low, 0);
        if (got) begin
            chk({tag, "_lat"}, n, exp_lat);
            chk({tag, "_data"}, cpu ? rd_data[k] : disp_data[k], exp);
            chk({tag, "_oth_ack"}, cpu ? disp_ack[k] : rd_ack[k], 0);
            chk({tag, "_oth_data"}, cpu ? disp_data[k] : rd_data[k], 0);
        end
        if (cpu) rd_req[k] = 1'b0; else disp_req[k] = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_drop"}, cpu ? rd_ack[k] : disp_ack[k], 0);
        chk({tag, "_data_zero"}, cpu ? rd_data[k] : disp_data[k], 0);
    endtask

    task automatic rd(int k, bit cpu, int a, string tag);
        logic [7:0] e = m_read(k, a);
        if (cpu) begin rd_req[k] = 1'b1; rd_addr[k] = 12'(a); end
        else     begin disp_req[k] = 1'b1; disp_addr[k] = 12'(a); end
        wait_ack(k, cpu, tag, 0, lat(k), e);
    endtask

    initial begin
        rst_n = '0; rd_req = '0; wr_req = '0; disp_req = '0;
        rd_addr = '0; wr_addr = '0; disp_addr = '0; wr_data = '0;
`ifdef FONT_ROM_EN
        for (int k = 0; k < NI; k++)
            for (int a = 'h50; a <= 'h9F; a++) known[k][a] = 1'b1;
`endif
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_rd_ack", rd_ack[k], 0);
            chk("rst_disp_ack", disp_ack[k], 0);
            chk("rst_rd_data", rd_data[k], 0);
            chk("rst_disp_data", disp_data[k], 0);
            chk("rst_busy", busy[k], 0);
        end
        rst_n = '1;
        @(negedge clk);

        for (int k = 0; k < NI; k++) begin
            wr(k, 'h200, 'hA5);
            rd(k, 1, 'h200, "rd200");
            wr(k, 'h123, 'h5C);
            rd(k, 1, 'h123, "rd123");

            // Simultaneous CPU and display requests
            wr(k, 'h010, 'h11);
            wr(k, 'h300, 'h22);
            rd_req[k] = 1'b1; rd_addr[k] = 12'h010;
            disp_req[k] = 1'b1; disp_addr[k] = 12'h300;
            wait_ack(k, 1, "arb_cpu", 0, lat(k), 8'h11);
            wait_ack(k, 0, "arb_disp", 0, lat(k), 8'h22);

            // Read and write to the same address in the same cycle
            wr(k, 'h020, 'h00);
            wr_req[k] = 1'b1; wr_addr[k] = 12'h020; wr_data[k] = 8'h7E;
            rd_req[k] = 1'b1; rd_addr[k] = 12'h020;
            @(negedge clk);
            wr_req[k] = 1'b0;
            m_write(k, 'h020, 'h7E);
            wait_ack(k, 1, "rdwr_same", 1, lat(k) + 1, 8'h7E);

            if (k == 1) begin
                // Write landing during WAIT must not disturb the captured byte
                rd_req[k] = 1'b1; rd_addr[k] = 12'h020;
                @(negedge clk);
                wr_req[k] = 1'b1; wr_addr[k] = 12'h020; wr_data[k] = 8'h33;
                @(negedge clk);
                wr_req[k] = 1'b0;
                wait_ack(k, 1, "wr_in_wait", 2, lat(k), 8'h7E);
                m_write(k, 'h020, 'h33);
                rd(k, 1, 'h020, "rd_after_wait_wr");

                // Reset during WAIT drops the read
                rd_req[k] = 1'b1; rd_addr[k] = 12'h200;
                repeat (2) @(negedge clk);
                rst_n[k] = 1'b0; rd_req[k] = 1'b0;
                #1;
                chk("midrst_rd_ack", rd_ack[k], 0);
                chk("midrst_rd_data", rd_data[k], 0);
                chk("midrst_busy", busy[k], 0);
                @(negedge clk);
                rst_n[k] = 1'b1;
                begin
                    int acks = 0;
                    repeat (8) begin
                        @(negedge clk);
                        if (rd_ack[k] !== 1'b0) acks++;
                    end
                    chk("midrst_no_ack", acks, 0);
                end
                rd(k, 1, 'h200, "rd_after_rst");
            end

            wr(k, 'h050, 'hFF);
            rd(k, 1, 'h050, "font050");
            wr(k, 'h09F, 'h3C);
            rd(k, 0, 'h09F, "font09F");
        end

        // Randomized traffic against the model
        for (int i = 0; i < 120; i++) begin
            int k = i % NI;
            int op = $urandom_range(0, 2);
            int a = $urandom_range(0, 4095);
            if (op == 0 || !known[k][a]) wr(k, a, $urandom_range(0, 255));
            if (op != 0) rd(k, op == 1, a, "rand_rd");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
